// File: rtl/subservient_pkg.sv
// Shared types for the subservient SRAM arbiter.
// Holds the WB port state encoding and RF address width default.
package subservient_pkg;

  localparam int RF_AW_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } port_st_t;

endpackage

// File: rtl/subservient_rr_arb2.sv
// Two-request round-robin arbiter, one-hot grant.
// Pointer flips to the other port after every grant.
module subservient_rr_arb2
  import subservient_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // ptr=0 favours port 0 on a tie
  logic ptr;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b00: o_gnt = 2'b00;
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: o_gnt = ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= 1'b0;
    end else if (|o_gnt) begin
      ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/subservient_sram_arb.sv
// RF-priority arbiter for a 1R1W SRAM shared with two WB ports.
// Define SUBSERVIENT_SRAM_ARB_RFPROT_EN to block WB access to the RF region.
module subservient_sram_arb
  import subservient_pkg::*;
#(
  parameter int aw      = 10,
  parameter int rf_aw   = RF_AW_DEFAULT,
  parameter int rf_base = 2**aw - 2**rf_aw
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [rf_aw-1:0] i_rf_waddr,
  input  logic [7:0]       i_rf_wdata,
  input  logic             i_rf_wen,
  input  logic [rf_aw-1:0] i_rf_raddr,
  input  logic             i_rf_ren,
  output logic [7:0]       o_rf_rdata,
  input  logic [aw-1:0]    i_wb0_adr,
  input  logic [7:0]       i_wb0_dat,
  input  logic             i_wb0_we,
  input  logic             i_wb0_stb,
  output logic [7:0]       o_wb0_rdt,
  output logic             o_wb0_ack,
  input  logic [aw-1:0]    i_wb1_adr,
  input  logic [7:0]       i_wb1_dat,
  input  logic             i_wb1_we,
  input  logic             i_wb1_stb,
  output logic [7:0]       o_wb1_rdt,
  output logic             o_wb1_ack,
  output logic [aw-1:0]    o_sram_waddr,
  output logic [7:0]       o_sram_wdata,
  output logic             o_sram_wen,
  output logic [aw-1:0]    o_sram_raddr,
  output logic             o_sram_ren,
  input  logic [7:0]       i_sram_rdata
);

  localparam logic [aw-1:0] RFB = aw'(rf_base);

  logic [aw-1:0] adr [2];
  logic [7:0]    dat [2];
  logic [1:0]    we;
  logic [1:0]    stb;
  logic [1:0]    prot;
  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic [1:0]    ack;
  logic [1:0]    rd_q;
  logic          gsel;
  logic          wb_wr;
  logic          wb_rd;
  logic          rf_rd_q;
  port_st_t      st [2];

  assign adr[0] = i_wb0_adr;
  assign adr[1] = i_wb1_adr;
  assign dat[0] = i_wb0_dat;
  assign dat[1] = i_wb1_dat;
  assign we     = {i_wb1_we, i_wb0_we};
  assign stb    = {i_wb1_stb, i_wb0_stb};

`ifdef SUBSERVIENT_SRAM_ARB_RFPROT_EN
  assign prot[0] = (i_wb0_adr >= RFB);
  assign prot[1] = (i_wb1_adr >= RFB);
`else
  assign prot = 2'b00;
`endif

  // Protected accesses need no SRAM port, so RF traffic never blocks them
  always_comb begin
    elig = 2'b00;
    for (int n = 0; n < 2; n++) begin
      elig[n] = i_rst_n & stb[n] & (st[n] == IDLE) &
                (prot[n] | (we[n] ? !i_rf_wen : !i_rf_ren));
    end
  end

  subservient_rr_arb2 u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (elig),
    .o_gnt   (gnt)
  );

  assign gsel  = gnt[1];
  assign wb_wr = (|gnt) & we[gsel] & !prot[gsel];
  assign wb_rd = (|gnt) & !we[gsel] & !prot[gsel];

  assign o_sram_wen   = i_rst_n & (i_rf_wen | wb_wr);
  assign o_sram_waddr = i_rf_wen ? (RFB | aw'(i_rf_waddr)) : adr[gsel];
  assign o_sram_wdata = i_rf_wen ? i_rf_wdata : dat[gsel];

  assign o_sram_ren   = i_rst_n & (i_rf_ren | wb_rd);
  assign o_sram_raddr = i_rf_ren ? (RFB | aw'(i_rf_raddr)) : adr[gsel];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rf_rd_q <= 1'b0;
      rd_q    <= 2'b00;
      st[0]   <= IDLE;
      st[1]   <= IDLE;
    end else begin
      rf_rd_q <= i_rf_ren;
      for (int n = 0; n < 2; n++) begin
        unique case (st[n])
          IDLE: begin
            if (gnt[n]) begin
              st[n]   <= ACK;
              rd_q[n] <= !we[n] & !prot[n];
            end
          end
          ACK: begin
            st[n]   <= IDLE;
            rd_q[n] <= 1'b0;
          end
          default: begin
            st[n]   <= IDLE;
            rd_q[n] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ack[0]     = (st[0] == ACK);
  assign ack[1]     = (st[1] == ACK);
  assign o_wb0_ack  = ack[0];
  assign o_wb1_ack  = ack[1];
  assign o_wb0_rdt  = (ack[0] & rd_q[0]) ? i_sram_rdata : 8'h00;
  assign o_wb1_rdt  = (ack[1] & rd_q[1]) ? i_sram_rdata : 8'h00;
  assign o_rf_rdata = rf_rd_q ? i_sram_rdata : 8'h00;

endmodule
